alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter FUNCT_W, default 6, funct field width.
REQ-002 SHALL have parameter ALUOP_W, default 4, ALUOp width (min 4).
REQ-003 SHALL have parameter CTRL_W, default 4, ALU control width (min 4).
REQ-004 SHALL have parameter MUL_LAT, default 4, multiply latency in cycles (min 2).
REQ-005 SHALL have port clk_i, input, 1, single clock; all state rises on posedge.
REQ-006 SHALL have port rst_i, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port valid_i, input, 1, upstream op valid.
REQ-008 SHALL have port ready_o, output, 1, block accepts an op this cycle.
REQ-009 SHALL have port funct_i, input, FUNCT_W, R-type funct field.
REQ-010 SHALL have port ALUOp_i, input, ALUOP_W, main-control op class.
REQ-011 SHALL have port valid_o, output, 1, decoded control valid.
REQ-012 SHALL have port ready_i, input, 1, downstream consumes control.
REQ-013 SHALL have port ALUCtrl_o, output, CTRL_W, ALU operation select.
REQ-014 SHALL have port bonus_control_o, output, 3, compare-variant select.
REQ-015 SHALL have port busy_o, output, 1, multiply in progress.
REQ-016 SHALL have port illegal_o, output, 1, held op undecodable.

Function
REQ-017 SHALL decode (zero-extended to CTRL_W, upper ALUOp bits zero): ALUOp 0000->0010; 0001->0110; 0100->0010; 0101->0001; all with bonus 000.
REQ-018 SHALL decode ALUOp 0010 by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 011000->1000 (MUL); bonus 000.
REQ-019 SHALL treat any other ALUOp/funct combination as illegal: ALUCtrl_o 1111, bonus 000, illegal_o 1, latency as non-MUL.
REQ-020 SHALL decode combinationally but register the result on accept; outputs are driven only from registers and stay stable until the output handshake completes.
REQ-021 SHALL implement FSM IDLE, HOLD, OUT; accept = valid_i && ready_o.
REQ-022 SHALL drive ready_o = (state==IDLE) || (state==OUT && ready_i).
REQ-023 SHALL on accept go to OUT for non-MUL ops, or to HOLD with counter loaded MUL_LAT-2 for MUL.
REQ-024 SHALL in HOLD decrement the counter each cycle, drive busy_o=1, valid_o=0, ignore valid_i, and go to OUT when the counter is 0.
REQ-025 SHALL in OUT drive valid_o=1; on ready_i go to IDLE, or, if an accept occurs in the same cycle, load the new op and go straight to OUT/HOLD (no bubble).
REQ-026 SHALL give latency accept-edge to valid_o: 1 cycle non-MUL, MUL_LAT cycles MUL.
REQ-027 SHALL hold valid_o and all outputs unchanged while OUT and ready_i=0.

Reset
REQ-028 SHALL on rst_i=0 immediately force state IDLE, counter 0, valid_o 0, busy_o 0, illegal_o 0, ALUCtrl_o 0, bonus_control_o 000.
REQ-029 SHALL abandon any in-flight op (HOLD or OUT) on reset with no valid_o pulse afterwards.
REQ-030 SHALL leave ready_o 1 from the first cycle after rst_i releases.

Configuration
REQ-031 SHALL, with ALU_CTRL_BONUS_EN defined, decode ALUOp 1000->0010/000, 1001->0111/101, 1010->0111/100, 1011->0111/001 (ALUCtrl/bonus).
REQ-032 SHALL, without ALU_CTRL_BONUS_EN, treat ALUOp 1000-1011 as illegal and hold bonus_control_o at 000.

Verification
REQ-033 SHALL cover: reset, ALUOp 0010 funct 100100, valid_i 1, ready_i 1 -> valid_o next cycle, ALUCtrl_o 0000, illegal_o 0.
REQ-034 SHALL cover: MUL (0010/011000), MUL_LAT=4 -> busy_o 1 for 3 cycles, valid_o in 4th cycle, ALUCtrl_o 1000, ready_o 0 meanwhile.
REQ-035 SHALL cover: back-to-back add then sub with ready_i 1 -> valid_o continuous 2 cycles, ALUCtrl_o 0010 then 0110.
REQ-036 SHALL cover: ready_i 0 for 5 cycles in OUT -> outputs frozen, ready_o 0, new valid_i not accepted.
REQ-037 SHALL cover: ALUOp 1010 -> 0111/100 with ALU_CTRL_BONUS_EN, 1111/000 and illegal_o 1 without.
REQ-038 SHALL cover: rst_i low during HOLD -> all outputs 0 immediately, no later valid_o.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequenced ALU control decoder.
//
// Decodes ALUOp/funct into an ALU operation select and a compare-variant
// select, registers the result on the input handshake and presents it
// through a valid/ready output handshake. MUL ops are held for MUL_LAT
// cycles (busy_o high) before the result is presented.
//
// Build option: define ALU_CTRL_BONUS_EN to enable the compare-variant
// ALUOp codes 1000-1011; without it those codes decode as illegal.
//
// Ports:
//   clk_i           clock, all state on posedge
//   rst_i           asynchronous reset, active-low
//   valid_i/ready_o input handshake (op offered / op accepted this cycle)
//   funct_i         R-type funct field
//   ALUOp_i         main-control op class
//   valid_o/ready_i output handshake (control valid / control consumed)
//   ALUCtrl_o       ALU operation select
//   bonus_control_o compare-variant select
//   busy_o          multiply in progress
//   illegal_o       held op was undecodable
module alu_ctrl_seq #(
   parameter int FUNCT_W = 6,
   parameter int ALUOP_W = 4,
   parameter int CTRL_W  = 4,
   parameter int MUL_LAT = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [CTRL_W-1:0]  ALUCtrl_o,
   output logic [2:0]         bonus_control_o,
   output logic               busy_o,
   output logic               illegal_o
);

   // Counter only has to hold MUL_LAT-2.
   localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_OUT
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [2:0]          bonus_q, bonus_d;
   logic                ill_q, ill_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;

   logic [CTRL_W-1:0]   dec_ctrl;
   logic [2:0]          dec_bonus;
   logic                dec_ill;
   logic                dec_mul;
   logic                accept;

   // Combinational decode; full ALUOp/funct compared so upper bits must be zero.
   always_comb begin
      dec_ctrl  = CTRL_W'(4'hF);
      dec_bonus = 3'b000;
      dec_ill   = 1'b1;
      dec_mul   = 1'b0;
      case (ALUOp_i)
         ALUOP_W'(4'h0): begin dec_ctrl = CTRL_W'(4'h2); dec_ill = 1'b0; end
         ALUOP_W'(4'h1): begin dec_ctrl = CTRL_W'(4'h6); dec_ill = 1'b0; end
         ALUOP_W'(4'h4): begin dec_ctrl = CTRL_W'(4'h2); dec_ill = 1'b0; end
         ALUOP_W'(4'h5): begin dec_ctrl = CTRL_W'(4'h1); dec_ill = 1'b0; end
         ALUOP_W'(4'h2): begin
            case (funct_i)
               FUNCT_W'(6'b100000): begin dec_ctrl = CTRL_W'(4'h2); dec_ill = 1'b0; end
               FUNCT_W'(6'b100010): begin dec_ctrl = CTRL_W'(4'h6); dec_ill = 1'b0; end
               FUNCT_W'(6'b100100): begin dec_ctrl = CTRL_W'(4'h0); dec_ill = 1'b0; end
               FUNCT_W'(6'b100101): begin dec_ctrl = CTRL_W'(4'h1); dec_ill = 1'b0; end
               FUNCT_W'(6'b101010): begin dec_ctrl = CTRL_W'(4'h7); dec_ill = 1'b0; end
               FUNCT_W'(6'b011000): begin
                  dec_ctrl = CTRL_W'(4'h8);
                  dec_ill  = 1'b0;
                  dec_mul  = 1'b1;
               end
               default: ;
            endcase
         end
`ifdef ALU_CTRL_BONUS_EN
         ALUOP_W'(4'h8): begin dec_ctrl = CTRL_W'(4'h2); dec_bonus = 3'b000; dec_ill = 1'b0; end
         ALUOP_W'(4'h9): begin dec_ctrl = CTRL_W'(4'h7); dec_bonus = 3'b101; dec_ill = 1'b0; end
         ALUOP_W'(4'hA): begin dec_ctrl = CTRL_W'(4'h7); dec_bonus = 3'b100; dec_ill = 1'b0; end
         ALUOP_W'(4'hB): begin dec_ctrl = CTRL_W'(4'h7); dec_bonus = 3'b001; dec_ill = 1'b0; end
`else
`endif
         default: ;
      endcase
   end

   // Next-state logic. An accept in OUT overrides the return to IDLE so
   // consecutive ops stream without a bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      bonus_d = bonus_q;
      ill_d   = ill_q;
      ready_o = (state_q == S_IDLE) || ((state_q == S_OUT) && ready_i);
      accept  = valid_i && ready_o;

      case (state_q)
         S_HOLD: begin
            if (cnt_q == '0) state_d = S_OUT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_OUT: begin
            if (ready_i) state_d = S_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         ctrl_d  = dec_ctrl;
         bonus_d = dec_bonus;
         ill_d   = dec_ill;
         if (dec_mul) begin
            state_d = S_HOLD;
            cnt_d   = CNT_LOAD;
         end else begin
            state_d = S_OUT;
         end
      end

      valid_d = (state_d == S_OUT);
      busy_d  = (state_d == S_HOLD);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ctrl_q  <= '0;
         bonus_q <= '0;
         ill_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         bonus_q <= bonus_d;
         ill_q   <= ill_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign valid_o         = valid_q;
   assign busy_o          = busy_q;
   assign ALUCtrl_o       = ctrl_q;
   assign bonus_control_o = bonus_q;
   assign illegal_o       = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: directed scenarios followed by random traffic,
// checked against a transaction-level reference model (decode table plus
// "result becomes visible at cycle N" timeline).
module tb_alu_ctrl_seq;

   localparam int FW = 6;
   localparam int AW = 4;
   localparam int CW = 4;
   localparam int ML = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          valid_i;
   logic          ready_o;
   logic [FW-1:0] funct_i;
   logic [AW-1:0] ALUOp_i;
   logic          valid_o;
   logic          ready_i;
   logic [CW-1:0] ALUCtrl_o;
   logic [2:0]    bonus_control_o;
   logic          busy_o;
   logic          illegal_o;

   alu_ctrl_seq #(
      .FUNCT_W(FW),
      .ALUOP_W(AW),
      .CTRL_W (CW),
      .MUL_LAT(ML)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .ready_o        (ready_o),
      .funct_i        (funct_i),
      .ALUOp_i        (ALUOp_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .ALUCtrl_o      (ALUCtrl_o),
      .bonus_control_o(bonus_control_o),
      .busy_o         (busy_o),
      .illegal_o      (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: one held op, visible from cycle m_vat onward.
   bit         m_have = 0;
   int         m_vat  = 0;
   logic [3:0] m_ctrl = '0;
   logic [2:0] m_bonus = '0;
   bit         m_ill  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decode table straight from the op list.
   task automatic ref_dec(input logic [3:0] op, input logic [5:0] fn,
                          output logic [3:0] ctrl, output logic [2:0] bonus,
                          output bit ill, output bit mul);
      ctrl = 4'hF; bonus = 3'b000; ill = 1; mul = 0;
      if (op == 4'h0 || op == 4'h4) begin ctrl = 4'h2; ill = 0; end
      else if (op == 4'h1) begin ctrl = 4'h6; ill = 0; end
      else if (op == 4'h5) begin ctrl = 4'h1; ill = 0; end
      else if (op == 4'h2) begin
         if      (fn == 6'b100000) begin ctrl = 4'h2; ill = 0; end
         else if (fn == 6'b100010) begin ctrl = 4'h6; ill = 0; end
         else if (fn == 6'b100100) begin ctrl = 4'h0; ill = 0; end
         else if (fn == 6'b100101) begin ctrl = 4'h1; ill = 0; end
         else if (fn == 6'b101010) begin ctrl = 4'h7; ill = 0; end
         else if (fn == 6'b011000) begin ctrl = 4'h8; ill = 0; mul = 1; end
      end
`ifdef ALU_CTRL_BONUS_EN
      else if (op == 4'h8) begin ctrl = 4'h2; bonus = 3'b000; ill = 0; end
      else if (op == 4'h9) begin ctrl = 4'h7; bonus = 3'b101; ill = 0; end
      else if (op == 4'hA) begin ctrl = 4'h7; bonus = 3'b100; ill = 0; end
      else if (op == 4'hB) begin ctrl = 4'h7; bonus = 3'b001; ill = 0; end
`endif
   endtask

   task automatic check_outs();
      bit ev;
      ev = m_have && (cyc >= m_vat);
      chk("valid_o", valid_o, ev);
      chk("busy_o", busy_o, m_have && (cyc < m_vat));
      if (ev) begin
         chk("ALUCtrl_o", ALUCtrl_o, m_ctrl);
         chk("bonus_control_o", bonus_control_o, m_bonus);
         chk("illegal_o", illegal_o, m_ill);
      end
   endtask

   // One clock cycle: drive inputs, check ready_o, advance the model, clock, check outputs.
   task automatic step(input bit v, input bit r, input logic [3:0] op, input logic [5:0] fn);
      bit hs, erdy, acc, mul;
      logic [3:0] c;
      logic [2:0] b;
      bit il;
      valid_i = v; ready_i = r; ALUOp_i = op; funct_i = fn;
      #1;
      hs   = m_have && (cyc >= m_vat) && r;
      erdy = !m_have || hs;
      chk("ready_o", ready_o, erdy);
      acc = v && erdy;
      if (hs) m_have = 0;
      if (acc) begin
         ref_dec(op, fn, c, b, il, mul);
         m_have = 1; m_ctrl = c; m_bonus = b; m_ill = il;
         m_vat = cyc + (mul ? ML : 1);
      end
      @(posedge clk_i);
      cyc++;
      #1;
      check_outs();
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, " valid_o"}, valid_o, 0);
      chk({tag, " busy_o"}, busy_o, 0);
      chk({tag, " illegal_o"}, illegal_o, 0);
      chk({tag, " ALUCtrl_o"}, ALUCtrl_o, 0);
      chk({tag, " bonus"}, bonus_control_o, 0);
   endtask

   initial begin
      logic [3:0] rop;
      logic [5:0] rfn;
      logic [5:0] legal_fn [6];
      legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
      legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010; legal_fn[5] = 6'b011000;

      rst_i = 1'b0; valid_i = 0; ready_i = 0; ALUOp_i = '0; funct_i = '0;
      #3;
      check_reset_outs("reset");
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("ready after reset", ready_o, 1);

      // AND: result one cycle after accept
      step(1, 1, 4'h2, 6'b100100);
      chk("and valid", valid_o, 1);
      chk("and ctrl", ALUCtrl_o, 4'h0);
      chk("and illegal", illegal_o, 0);
      step(0, 1, 4'h0, 6'h0);

      // MUL: 3 busy cycles, valid in the 4th, new ops ignored meanwhile
      step(1, 1, 4'h2, 6'b011000);
      chk("mul busy1", busy_o, 1);
      step(1, 1, 4'h2, 6'b100000);
      step(1, 1, 4'h2, 6'b100000);
      chk("mul busy3", busy_o, 1);
      step(1, 1, 4'h2, 6'b100000);
      chk("mul valid", valid_o, 1);
      chk("mul ctrl", ALUCtrl_o, 4'h8);
      step(0, 1, 4'h0, 6'h0);

      // back-to-back add then sub
      step(1, 1, 4'h2, 6'b100000);
      chk("b2b add", ALUCtrl_o, 4'h2);
      step(1, 1, 4'h2, 6'b100010);
      chk("b2b valid2", valid_o, 1);
      chk("b2b sub", ALUCtrl_o, 4'h6);
      step(0, 1, 4'h0, 6'h0);

      // downstream stall for 5 cycles
      step(1, 1, 4'h2, 6'b101010);
      for (int i = 0; i < 5; i++) step(1, 0, 4'h1, 6'h0);
      chk("stall ctrl", ALUCtrl_o, 4'h7);
      step(0, 1, 4'h0, 6'h0);

      // compare-variant op
      step(1, 1, 4'hA, 6'h0);
`ifdef ALU_CTRL_BONUS_EN
      chk("bonus ctrl", ALUCtrl_o, 4'h7);
      chk("bonus sel", bonus_control_o, 3'b100);
`else
      chk("bonus ctrl", ALUCtrl_o, 4'hF);
      chk("bonus illegal", illegal_o, 1);
`endif
      step(0, 1, 4'h0, 6'h0);

      // reset during HOLD abandons the multiply
      step(1, 1, 4'h2, 6'b011000);
      step(0, 1, 4'h0, 6'h0);
      #2;
      rst_i = 1'b0;
      #1;
      check_reset_outs("rst in hold");
      m_have = 0;
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 6; i++) step(0, 1, 4'h0, 6'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rop = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
         rfn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 5)]
                                           : 6'($urandom_range(0, 63));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rop, rfn);
      end
      for (int i = 0; i < 8; i++) step(0, 1, 4'h0, 6'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
